// File: rtl/dma_line_fifo.sv
// Cache-line FIFO between host read responses and dma_fsm; first-word-fall-through head, flags one cycle after push/pop.
// Host is throttled by host_rd_ready = !full; optional registered almost_full under DMA_LINE_FIFO_ALMOST_FULL_EN.
module dma_line_fifo #(
   parameter int CL_SIZE_WIDTH = 512,
   parameter int DEPTH         = 8,
   parameter int AF_MARGIN     = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       host_rd_valid,
   input  logic [CL_SIZE_WIDTH-1:0]   host_rd_data,
   output logic                       host_rd_ready,
   input  logic                       dma_pop,
   output logic [CL_SIZE_WIDTH-1:0]   dma_rd_data,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       almost_full,
   output logic                       err_underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] AF_THRESH = (AW+1)'(DEPTH - AF_MARGIN);

   logic [CL_SIZE_WIDTH-1:0] mem [DEPTH];
   logic [AW:0]              wr_ptr;
   logic [AW:0]              rd_ptr;
   logic [AW:0]              count_nxt;
   logic                     push;
   logic                     pop;

   // Extra MSB on each pointer tells full from empty when the low bits match.
   assign empty         = (wr_ptr == rd_ptr);
   assign full          = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign host_rd_ready = !full;

   assign push = host_rd_valid && !full;
   assign pop  = dma_pop && !empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_comb begin
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + (AW+1)'(1);
         2'b01:   count_nxt = count - (AW+1)'(1);
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count         <= '0;
         err_underflow <= 1'b0;
      end else begin
         count <= count_nxt;
         if (dma_pop && empty) err_underflow <= 1'b1;
      end
   end

   // Storage is deliberately left unreset; pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= host_rd_data;
   end

   assign dma_rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

`ifdef DMA_LINE_FIFO_ALMOST_FULL_EN
   logic af_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) af_q <= 1'b0;
      else        af_q <= (count_nxt >= AF_THRESH);
   end

   assign almost_full = af_q;
`else
   logic unused_af_thresh;

   assign unused_af_thresh = ^AF_THRESH;
   assign almost_full      = 1'b0;
`endif

endmodule

// File: tb/tb_dma_line_fifo.sv
// Directed bench for dma_line_fifo (DEPTH=8, AF_MARGIN=2); almost_full expectation follows the build macro.
module tb_dma_line_fifo;

   localparam int W = 512;

`ifdef DMA_LINE_FIFO_ALMOST_FULL_EN
   localparam bit AF_EN = 1'b1;
`else
   localparam bit AF_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic         host_rd_valid;
   logic [W-1:0] host_rd_data;
   logic         host_rd_ready;
   logic         dma_pop;
   logic [W-1:0] dma_rd_data;
   logic         empty;
   logic         full;
   logic [3:0]   count;
   logic         almost_full;
   logic         err_underflow;

   int n_tests = 0;
   int n_fail  = 0;

   logic [W-1:0] q [$];

   dma_line_fifo #(.CL_SIZE_WIDTH(W), .DEPTH(8), .AF_MARGIN(2)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .host_rd_valid (host_rd_valid),
      .host_rd_data  (host_rd_data),
      .host_rd_ready (host_rd_ready),
      .dma_pop       (dma_pop),
      .dma_rd_data   (dma_rd_data),
      .empty         (empty),
      .full          (full),
      .count         (count),
      .almost_full   (almost_full),
      .err_underflow (err_underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] mk_line(input int base);
      logic [W-1:0] l;
      for (int i = 0; i < 16; i++) l[i*32 +: 32] = 32'(base*16 + i);
      return l;
   endfunction

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_af(input string tag, input int cnt);
      chk(tag, W'(almost_full), W'(AF_EN && (cnt >= 6)));
   endtask

   initial begin
      rst_n = 1'b0; host_rd_valid = 1'b0; host_rd_data = '0; dma_pop = 1'b0;
      #3;
      chk("rst_empty", W'(empty), W'(1));
      chk("rst_full", W'(full), W'(0));
      chk("rst_ready", W'(host_rd_ready), W'(1));
      chk("rst_count", W'(count), W'(0));
      chk("rst_af", W'(almost_full), W'(0));
      chk("rst_err", W'(err_underflow), W'(0));
      chk("rst_data", dma_rd_data, '0);
      cycle();
      rst_n = 1'b1;

      // single line: empty stays high in the push cycle
      host_rd_valid = 1'b1; host_rd_data = mk_line(0);
      chk("push_cycle_empty", W'(empty), W'(1));
      cycle();
      host_rd_valid = 1'b0;
      chk("one_empty", W'(empty), W'(0));
      chk("one_count", W'(count), W'(1));
      chk("one_data", dma_rd_data, mk_line(0));
      dma_pop = 1'b1;
      cycle();
      dma_pop = 1'b0;
      chk("one_pop_empty", W'(empty), W'(1));
      chk("one_pop_data", dma_rd_data, '0);
      chk("one_pop_err", W'(err_underflow), W'(0));

      // fill to DEPTH
      for (int i = 1; i <= 8; i++) begin
         host_rd_valid = 1'b1; host_rd_data = mk_line(i);
         cycle();
         chk_af($sformatf("fill_af_%0d", i), i);
         chk($sformatf("fill_count_%0d", i), W'(count), W'(i));
      end
      chk("full_flag", W'(full), W'(1));
      chk("full_ready", W'(host_rd_ready), W'(0));
      host_rd_data = mk_line(99);
      cycle();
      chk("ninth_count", W'(count), W'(8));
      chk("ninth_head", dma_rd_data, mk_line(1));

      // push+pop while full: pop wins, push refused
      dma_pop = 1'b1;
      chk("fullpp_head", dma_rd_data, mk_line(1));
      cycle();
      host_rd_valid = 1'b0;
      chk("fullpp_count", W'(count), W'(7));
      chk("fullpp_full", W'(full), W'(0));
      for (int i = 2; i <= 8; i++) begin
         chk($sformatf("drain_data_%0d", i), dma_rd_data, mk_line(i));
         cycle();
      end
      dma_pop = 1'b0;
      chk("drain_empty", W'(empty), W'(1));
      chk("drain_err", W'(err_underflow), W'(0));

      // push+pop while empty: push taken, underflow flagged
      host_rd_valid = 1'b1; host_rd_data = mk_line(20); dma_pop = 1'b1;
      cycle();
      host_rd_valid = 1'b0; dma_pop = 1'b0;
      chk("emptypp_count", W'(count), W'(1));
      chk("emptypp_err", W'(err_underflow), W'(1));
      chk("emptypp_data", dma_rd_data, mk_line(20));
      q.push_back(mk_line(20));

      // steady streaming with occupancy 1..3 across pointer wrap
      for (int i = 0; i < 20; i++) begin
         logic do_push, do_pop;
         do_push = (i % 3) != 2;
         do_pop  = (i % 3) != 0;
         host_rd_valid = do_push; host_rd_data = mk_line(30 + i); dma_pop = do_pop;
         chk($sformatf("wrap_head_%0d", i), dma_rd_data, q[0]);
         cycle();
         if (do_pop)  void'(q.pop_front());
         if (do_push) q.push_back(mk_line(30 + i));
         chk($sformatf("wrap_count_%0d", i), W'(count), W'(q.size()));
         chk($sformatf("wrap_flags_%0d", i), W'({empty, full}), W'(2'b00));
      end
      host_rd_valid = 1'b0;
      while (q.size() > 0) begin
         dma_pop = 1'b1;
         chk("wrap_drain", dma_rd_data, q[0]);
         cycle();
         void'(q.pop_front());
      end
      dma_pop = 1'b0;
      chk("wrap_end_empty", W'(empty), W'(1));

      // almost_full threshold
      for (int i = 1; i <= 6; i++) begin
         host_rd_valid = 1'b1; host_rd_data = mk_line(60 + i);
         cycle();
      end
      host_rd_valid = 1'b0;
      chk_af("af_six", 6);
      dma_pop = 1'b1;
      cycle();
      dma_pop = 1'b0;
      chk_af("af_five", 5);
      chk("af_five_count", W'(count), W'(5));

      // asynchronous reset mid-cycle with 5 lines stored
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_empty", W'(empty), W'(1));
      chk("arst_full", W'(full), W'(0));
      chk("arst_count", W'(count), W'(0));
      chk("arst_err", W'(err_underflow), W'(0));
      chk("arst_data", dma_rd_data, '0);
      chk("arst_ready", W'(host_rd_ready), W'(1));
      chk("arst_af", W'(almost_full), W'(0));
      #2;
      rst_n = 1'b1;
      dma_pop = 1'b1;
      cycle();
      dma_pop = 1'b0;
      chk("post_rst_pop_count", W'(count), W'(0));
      chk("post_rst_pop_empty", W'(empty), W'(1));
      chk("post_rst_pop_err", W'(err_underflow), W'(1));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dma_line_fifo.md
DMA_LINE_FIFO -- requirements
Module: dma_line_fifo

Interface
REQ-001 Parameter CL_SIZE_WIDTH, default 512, cache-line width in bits.
REQ-002 Parameter DEPTH, default 8, number of line entries; power of two, at least 2.
REQ-003 Parameter AF_MARGIN, default 2, free-entry margin for almost_full.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 host_rd_valid  input  1  host read-response line valid.
REQ-007 host_rd_data  input  CL_SIZE_WIDTH  host read-response line.
REQ-008 host_rd_ready  output  1  FIFO can accept a line.
REQ-009 dma_pop  input  1  dma_fsm consumes the head line.
REQ-010 dma_rd_data  output  CL_SIZE_WIDTH  head line, first-word-fall-through.
REQ-011 empty  output  1  no lines stored.
REQ-012 full  output  1  DEPTH lines stored.
REQ-013 count  output  $clog2(DEPTH)+1  lines stored.
REQ-014 almost_full  output  1  count >= DEPTH-AF_MARGIN (see Configuration).
REQ-015 err_underflow  output  1  sticky; pop attempted while empty.

Function
REQ-016 host_rd_ready SHALL equal !full, combinationally.
REQ-017 Push SHALL occur at a rising edge where host_rd_valid && host_rd_ready; the line is written at the write pointer.
REQ-018 Pop SHALL occur at a rising edge where dma_pop && !empty; the read pointer advances.
REQ-019 Read and write pointers SHALL be $clog2(DEPTH)+1 bits, wrap modulo 2*DEPTH, and address storage with their low bits.
REQ-020 empty SHALL be asserted when the pointers are equal; full SHALL be asserted when the low bits are equal and the MSBs differ.
REQ-021 count SHALL be registered, incrementing on push-only, decrementing on pop-only, and unchanged on simultaneous push and pop.
REQ-022 Flag latency: a push into an empty FIFO SHALL deassert empty on the following cycle; no same-cycle bypass.
REQ-023 dma_rd_data SHALL present storage[rd_ptr] whenever empty=0, and all-zero when empty=1.
REQ-024 Simultaneous push and pop while full: pop accepted, push refused (ready=0); count goes to DEPTH-1.
REQ-025 Simultaneous push and pop while empty: push accepted, pop ignored, err_underflow set; count goes to 1.
REQ-026 dma_pop while empty SHALL change no pointer and SHALL set err_underflow, which holds until reset.
REQ-027 host_rd_valid while full SHALL not alter storage or pointers; the host holds data (valid/ready rule).

Reset
REQ-028 Assertion of rst_n=0 SHALL immediately clear both pointers, count, and err_underflow, and SHALL force empty=1, full=0, almost_full=0, host_rd_ready=1, and dma_rd_data=0.
REQ-029 Storage contents SHALL not be reset; reset mid-transfer discards all stored lines.
REQ-030 The first push SHALL be accepted at the first rising edge after rst_n deasserts.

Configuration
REQ-031 Macro DMA_LINE_FIFO_ALMOST_FULL_EN: when defined, almost_full SHALL be registered and equal to (count >= DEPTH-AF_MARGIN), updated with count.
REQ-032 When DMA_LINE_FIFO_ALMOST_FULL_EN is undefined, the almost_full port SHALL remain present and be tied to 0.

Verification
REQ-033 Reset, then push one line {32'd0..32'd15} -> empty=1 in the push cycle; next cycle empty=0, count=1, dma_rd_data equals the line; pop -> empty=1, dma_rd_data=0.
REQ-034 Push 8 distinct lines with DEPTH=8 -> full=1, host_rd_ready=0, count=8; a ninth valid is refused; 8 pops return lines in order 0..7.
REQ-035 Push and pop in the same cycle while full -> count=7, full=0, the refused line is not stored; push and pop while empty -> count=1, err_underflow=1.
REQ-036 Run 20 push/pop cycles with count between 1 and 3 -> pointers wrap, data order is preserved, no false full or empty.
REQ-037 With the macro defined, DEPTH=8 and AF_MARGIN=2, push 6 lines -> almost_full=1 after the 6th push and 0 after one pop; without the macro, almost_full=0 throughout.
REQ-038 Pull rst_n low asynchronously with 5 lines stored -> flags, count, and err_underflow reset immediately without a clock edge; the next pop is ignored.
